bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: W, default 16, word width in bits; legal range is W >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  W  parallel word, typically the output of the bit-reversal stage.
REQ-005 lsb_first  input  1  bit order for the word being loaded: 1 = din[0] first, 0 = din[W-1] first.
REQ-006 in_valid  input  1  din and lsb_first are valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_valid  output  1  sout is valid.
REQ-010 sout_ready  input  1  downstream consumes sout this cycle.
REQ-011 sout_last  output  1  current sout is the final bit of the word.
REQ-012 busy  output  1  a word is being shifted out.

Function
REQ-013 A word is accepted in any cycle where in_valid & in_ready are both high (the load handshake).
REQ-014 The state machine has two states: IDLE and SHIFT.
- IDLE -> SHIFT on a load handshake.
- SHIFT -> IDLE when the last bit is consumed and no new load occurs in the same cycle.
- SHIFT -> SHIFT (reload) when the last bit is consumed and a load occurs in the same cycle.
REQ-015 in_ready = (state == IDLE) | (sout_valid & sout_ready & sout_last); this combinational path allows back-to-back words with no bubble.
REQ-016 On load, din and lsb_first are registered together; lsb_first changes after load have no effect on the word in flight.
REQ-017 First-bit latency is 1 cycle: sout_valid rises on the clock edge that performs the load.
- The first sout is din[W-1] when lsb_first = 0, and din[0] when lsb_first = 1.
REQ-018 Each cycle with sout_valid & sout_ready advances to the next bit in the selected order; exactly W bits are emitted per word.
REQ-019 A bit counter of width $clog2(W) counts consumed bits.
- sout_last = sout_valid & (count == W-1).
- The counter clears on every load.
REQ-020 While sout_valid is high and sout_ready is low, sout, sout_last and the internal state hold unchanged, for any number of cycles.
REQ-021 When sout_valid = 0, sout = 0 and sout_last = 0.
REQ-022 busy = (state == SHIFT); busy stays high continuously across back-to-back words.
REQ-023 in_valid while in_ready = 0 is ignored; the word is not captured, and upstream holds it until a later load handshake.
REQ-024 All outputs except in_ready are registered; in_ready is combinational as defined in REQ-015.

Reset
REQ-025 Asserting rst_n low immediately forces:
- state = IDLE, counter = 0, shift register = 0;
- sout = 0, sout_valid = 0, sout_last = 0, busy = 0;
- in_ready = 1.
REQ-026 Reset asserted mid-word discards the remaining bits; no partial word resumes after reset is released.
REQ-027 The first load handshake is possible on the first rising edge after rst_n is released.

Structure
REQ-028 The state encodings and the counter-width expression are defined in the shared project package/include file, alongside other common constants.
REQ-029 A single leaf sub-module, bit_counter (parameterised modulo-W counter with clear, enable and terminal-count output), is instantiated.
- The shift datapath and FSM live in bit_serializer itself.

Verification
REQ-030 W=16, din=16'b1000000001111000, lsb_first=0, sout_ready=1 -> sout sequence 1,0,0,0,0,0,0,0,0,1,1,1,1,0,0,0.
- sout_last is high only on bit 16.
- busy is high for 16 cycles.
REQ-031 The same din with lsb_first=1 -> sout sequence 0,0,0,1,1,1,1,0,0,0,0,0,0,0,0,1; first bit appears 1 cycle after load.
REQ-032 din=16'b1111000000000000, lsb_first=0, sout_ready held low for 5 cycles after bit 3 -> bit 3 (value 1) is held stable for all 5 cycles.
- The total emitted sequence is unchanged: 1,1,1,1 followed by twelve 0s.
REQ-033 Back-to-back: 16'b1000000000000111 (lsb_first=1) then 16'hFFFF (lsb_first=0), with in_valid held high.
- in_ready pulses high with sout_last of word 1.
- 32 consecutive valid bits with no gap.
- busy never drops between the two words.
REQ-034 Reset mid-word: rst_n low after bit 7 of 16'hA5A5 -> sout_valid, busy and sout_last go 0 at once.
- After release, the next word 16'h0001 (lsb_first=1) emits 1 followed by fifteen 0s.
REQ-035 in_valid asserted while busy with a different din -> that word is ignored until in_ready is high, and the current word completes uncorrupted.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer slice.
// Contents: default word width, FSM state encoding, counter-width helper.
package bit_serializer_pkg;

  localparam int unsigned DefaultW = 16;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Width of a counter that indexes 0..w-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Handshake bundle for the bit serializer.
// Parallel side: din, lsb_first, in_valid (to block), in_ready (from block).
// Serial side  : sout, sout_valid, sout_last, busy (from block), sout_ready (to block).
// modport master = upstream/downstream environment, modport slave = the serializer.
interface bit_serializer_if #(
  parameter int unsigned W = bit_serializer_pkg::DefaultW
);
  logic [W-1:0] din;
  logic         lsb_first;
  logic         in_valid;
  logic         in_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         sout_last;
  logic         busy;

  modport master (
    output din, lsb_first, in_valid, sout_ready,
    input  in_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, lsb_first, in_valid, sout_ready,
    output in_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/bit_counter.sv
// Modulo counter with synchronous clear and enable.
// Ports: clk, rst_n (async, active low), clr (to zero, wins over en),
//        en (advance, wraps at Modulo-1), count (current value), tc (count == Modulo-1).
module bit_counter #(
  parameter int unsigned Modulo = 16,
  parameter int unsigned Width  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             tc
);
  logic [Width-1:0] count_q, count_d;

  assign tc    = (count_q == Width'(Modulo - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides.
// Ports: clk, rst_n (async, active low), bus (bit_serializer_if.slave):
//   din/lsb_first/in_valid/in_ready load a word; sout/sout_valid/sout_ready/sout_last
//   stream it out one bit per consumed cycle; busy marks a word in flight.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serializer_if.slave     bus
);
  localparam int unsigned CntW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    din_ord;
  logic            last_q, last_d;
  logic [CntW-1:0] count;
  logic            tc;
  logic            valid;
  logic            adv;
  logic            load;

  // Word is stored pre-ordered so the next bit is always the MSB; zero fill
  // guarantees sout reads 0 once the word has drained.
  always_comb begin
    din_ord = '0;
    for (int i = 0; i < W; i++) begin
      din_ord[i] = bus.lsb_first ? bus.din[W-1-i] : bus.din[i];
    end
  end

  assign valid        = (state_q == StShift);
  assign adv          = valid & bus.sout_ready;
  // Combinational so a new word can load in the cycle the last bit leaves.
  assign bus.in_ready = (state_q == StIdle) | (adv & last_q);
  assign load         = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    last_d  = last_q;

    case (state_q)
      StIdle:  if (load) state_d = StShift;
      StShift: if (adv && tc) state_d = load ? StShift : StIdle;
      default: state_d = StIdle;
    endcase

    if (load) begin
      shreg_d = din_ord;
      last_d  = 1'b0;
    end else if (adv) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
      last_d  = (count == CntW'(W - 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  bit_counter #(
    .Modulo (W),
    .Width  (CntW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (adv),
    .count (count),
    .tc    (tc)
  );

  assign bus.sout       = shreg_q[W-1];
  assign bus.sout_valid = valid;
  assign bus.sout_last  = last_q;
  assign bus.busy       = valid;
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (W = 16): directed scenarios plus random
// traffic, checked every cycle against a bit-queue reference model.
module tb_bit_serializer;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;

  bit_serializer_if #(.W(W)) bus ();

  bit_serializer #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  string       phase = "reset";

  bit          exp_q[$];   // bits still to be emitted, head = current sout
  logic [W:0]  src_q[$];   // words waiting upstream: {lsb_first, din}
  bit          rdy;

  // Observed/expected packed as {in_ready, sout_valid, sout, sout_last, busy}.
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %b expected %b (in_ready,valid,sout,last,busy)",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] observed();
    return {bus.in_ready, bus.sout_valid, bus.sout, bus.sout_last, bus.busy};
  endfunction

  task automatic push_word(input logic [W:0] w);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(w[W] ? w[i] : w[W-1-i]);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance the model at the edge.
  task automatic step(input bit gate);
    bit e_ir, e_v, e_s, e_l, adv, ld;
    bus.in_valid = gate && (src_q.size() > 0);
    if (src_q.size() > 0) begin
      {bus.lsb_first, bus.din} = src_q[0];
    end else begin
      bus.din       = 16'($urandom);
      bus.lsb_first = 1'($urandom);
    end
    bus.sout_ready = rdy;
    @(negedge clk);
    e_v  = (exp_q.size() > 0);
    e_s  = e_v ? exp_q[0] : 1'b0;
    e_l  = (exp_q.size() == 1);
    e_ir = !e_v || (rdy && e_l);
    check(phase, observed(), {e_ir, e_v, e_s, e_l, e_v});
    adv = rdy && e_v;
    ld  = bus.in_valid && e_ir;
    if (adv) void'(exp_q.pop_front());
    if (ld) push_word(src_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.lsb_first  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.sout_ready = 1'b0;
    rdy            = 1'b0;
    #12;
    check("reset", observed(), 5'b10000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    phase = "msb_first";
    rdy = 1'b1;
    src_q.push_back({1'b0, 16'b1000000001111000});
    repeat (18) step(1'b1);

    phase = "lsb_first";
    src_q.push_back({1'b1, 16'b1000000001111000});
    repeat (18) step(1'b1);

    phase = "stall";
    src_q.push_back({1'b0, 16'b1111000000000000});
    for (int k = 0; k < 26; k++) begin
      rdy = !(k >= 3 && k < 8);
      step(1'b1);
    end

    phase = "back_to_back";
    rdy = 1'b1;
    src_q.push_back({1'b1, 16'b1000000000000111});
    src_q.push_back({1'b0, 16'hFFFF});
    repeat (36) step(1'b1);

    phase = "reset_mid";
    src_q.push_back({1'b0, 16'hA5A5});
    for (int k = 0; k < 20 && exp_q.size() != 9; k++) step(1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", observed(), 5'b10000);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    phase = "after_reset";
    src_q.push_back({1'b1, 16'h0001});
    repeat (18) step(1'b1);

    phase = "ignored_while_busy";
    src_q.push_back({1'b0, 16'h1234});
    src_q.push_back({1'b1, 16'hBEEF});
    for (int k = 0; k < 40; k++) begin
      rdy = (k % 3) != 1;
      step(1'b1);
    end

    phase = "random";
    repeat (25) src_q.push_back({1'($urandom), 16'($urandom)});
    for (int k = 0; k < 3000 && (src_q.size() > 0 || exp_q.size() > 0); k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0);
    end
    rdy = 1'b1;
    repeat (4) step(1'b0);
    check("drained", {3'b000, 1'(src_q.size() > 0), 1'(exp_q.size() > 0)}, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
